// File: rtl/beta_pkg.sv
// Shared definitions for the Beta-style core: widths, special registers,
// bypass-source encoding and the pipeline-stage hit test.
package beta_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [AW-1:0] XP_REG   = 5'd30;
  localparam logic [AW-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_WB  = 2'd3
  } byp_sel_e;

  // A stage supplies x only if it really writes x; r31 is never forwarded.
  function automatic logic stage_hit(input logic          valid,
                                     input logic          werf,
                                     input logic [AW-1:0] wa,
                                     input logic [AW-1:0] x);
    return valid && werf && (wa == x) && (x != ZERO_REG);
  endfunction

endpackage

// File: rtl/bypass_mux.sv
// Per-operand bypass select (ALU > MEM > WB > regfile) with load-use and
// WB-block flags. Optional WB leg controlled by OPSTAGE_WB_BYPASS_EN.
module bypass_mux
  import beta_pkg::*;
(
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_hit,
  input  logic          mem_hit,
  input  logic          wb_hit,
  input  logic          ex_is_ld,
  input  logic [DW-1:0] ex_data,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data,
  output logic          load_use,
  output logic          wb_block
);

  byp_sel_e sel_s;

  // Source selection by stage priority.
  always_comb begin
    sel_s = SEL_RF;
    if (ex_hit) begin
      sel_s = SEL_EX;
    end else if (mem_hit) begin
      sel_s = SEL_MEM;
    end
`ifdef OPSTAGE_WB_BYPASS_EN
    else if (wb_hit) begin
      sel_s = SEL_WB;
    end
`endif
    else begin
      sel_s = SEL_RF;
    end
  end

  // Data mux; r31 reads as zero regardless of any hit or regfile content.
  always_comb begin
    data = {DW{1'b0}};
    if (addr == ZERO_REG) begin
      data = {DW{1'b0}};
    end else begin
      case (sel_s)
        SEL_EX:  data = ex_data;
        SEL_MEM: data = mem_data;
        SEL_WB:  data = wb_data;
        SEL_RF:  data = rf_data;
        default: data = rf_data;
      endcase
    end
  end

  assign load_use = ex_hit && ex_is_ld;

`ifdef OPSTAGE_WB_BYPASS_EN
  assign wb_block = 1'b0;
`else
  // Without the WB leg the value is only visible once the regfile is written.
  assign wb_block = wb_hit;
`endif

endmodule

// File: rtl/operand_stage.sv
// RF->ALU operand stage: operand B addressing, bypass, load-use stall and
// ALU-stage registers. WB bypass is enabled by OPSTAGE_WB_BYPASS_EN.
module operand_stage
  import beta_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          rf_valid,
  input  logic [AW-1:0] rf_ra,
  input  logic [AW-1:0] rf_rb,
  input  logic [AW-1:0] rf_rc,
  input  logic          rf_ra2sel,
  input  logic          rf_wasel,
  input  logic          rf_werf,
  input  logic          rf_is_ld,
  input  logic [DW-1:0] radata,
  input  logic [DW-1:0] rbdata,
  output logic [AW-1:0] rb_addr,
  input  logic          annul,
  input  logic          ex_valid,
  input  logic          ex_werf,
  input  logic          ex_is_ld,
  input  logic [AW-1:0] ex_wa,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_valid,
  input  logic          mem_werf,
  input  logic [AW-1:0] mem_wa,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_valid,
  input  logic          wb_werf,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wdata,
  output logic          stall,
  output logic          alu_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [AW-1:0] alu_wa,
  output logic          alu_werf,
  output logic          alu_is_ld
);

  logic [AW-1:0] wa_s;
  logic [DW-1:0] opa_s, opb_s;
  logic          lu_a_s, lu_b_s, wbb_a_s, wbb_b_s;

  assign rb_addr = rf_ra2sel ? rf_rc : rf_rb;
  assign wa_s    = rf_wasel ? XP_REG : rf_rc;

  bypass_mux u_mux_a (
    .addr     (rf_ra),
    .rf_data  (radata),
    .ex_hit   (stage_hit(ex_valid, ex_werf, ex_wa, rf_ra)),
    .mem_hit  (stage_hit(mem_valid, mem_werf, mem_wa, rf_ra)),
    .wb_hit   (stage_hit(wb_valid, wb_werf, wb_wa, rf_ra)),
    .ex_is_ld (ex_is_ld),
    .ex_data  (ex_result),
    .mem_data (mem_result),
    .wb_data  (wb_wdata),
    .data     (opa_s),
    .load_use (lu_a_s),
    .wb_block (wbb_a_s)
  );

  bypass_mux u_mux_b (
    .addr     (rb_addr),
    .rf_data  (rbdata),
    .ex_hit   (stage_hit(ex_valid, ex_werf, ex_wa, rb_addr)),
    .mem_hit  (stage_hit(mem_valid, mem_werf, mem_wa, rb_addr)),
    .wb_hit   (stage_hit(wb_valid, wb_werf, wb_wa, rb_addr)),
    .ex_is_ld (ex_is_ld),
    .ex_data  (ex_result),
    .mem_data (mem_result),
    .wb_data  (wb_wdata),
    .data     (opb_s),
    .load_use (lu_b_s),
    .wb_block (wbb_b_s)
  );

  // Stall request; an annulled instruction never stalls.
  always_comb begin
    stall = 1'b0;
    if (annul || !rf_valid) begin
      stall = 1'b0;
    end else begin
      stall = lu_a_s || lu_b_s || wbb_a_s || wbb_b_s;
    end
  end

  // ALU-stage registers; bubbles keep the datapath fields unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_valid <= 1'b0;
      alu_a     <= {DW{1'b0}};
      alu_b     <= {DW{1'b0}};
      alu_wa    <= {AW{1'b0}};
      alu_werf  <= 1'b0;
      alu_is_ld <= 1'b0;
    end else if (annul || stall || !rf_valid) begin
      alu_valid <= 1'b0;
      alu_werf  <= 1'b0;
      alu_is_ld <= 1'b0;
    end else begin
      alu_valid <= 1'b1;
      alu_a     <= opa_s;
      alu_b     <= opb_s;
      alu_wa    <= wa_s;
      alu_werf  <= rf_werf;
      alu_is_ld <= rf_is_ld;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios then random cycles
// against a behavioural register/bypass model. Honours OPSTAGE_WB_BYPASS_EN.
module tb_operand_stage;
  import beta_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          rf_valid, rf_ra2sel, rf_wasel, rf_werf, rf_is_ld, annul;
  logic [AW-1:0] rf_ra, rf_rb, rf_rc, rb_addr;
  logic [DW-1:0] radata, rbdata;
  logic          ex_valid, ex_werf, ex_is_ld, mem_valid, mem_werf, wb_valid, wb_werf;
  logic [AW-1:0] ex_wa, mem_wa, wb_wa;
  logic [DW-1:0] ex_result, mem_result, wb_wdata;
  logic          stall, alu_valid, alu_werf, alu_is_ld;
  logic [DW-1:0] alu_a, alu_b;
  logic [AW-1:0] alu_wa;

  logic [DW-1:0] regs [32];
  int errors = 0;
  int checks = 0;

  logic          m_valid = 1'b0, m_werf = 1'b0, m_ld = 1'b0;
  logic [DW-1:0] m_a = 32'd0, m_b = 32'd0;
  logic [AW-1:0] m_wa = 5'd0;
  logic          stall_seen;

  always #5 clock = ~clock;

  // Regfile read ports are combinational.
  always_comb begin
    radata = regs[rf_ra];
    rbdata = regs[rb_addr];
  end

  operand_stage dut (
    .clock(clock), .reset(reset), .rf_valid(rf_valid), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_rc(rf_rc), .rf_ra2sel(rf_ra2sel), .rf_wasel(rf_wasel), .rf_werf(rf_werf),
    .rf_is_ld(rf_is_ld), .radata(radata), .rbdata(rbdata), .rb_addr(rb_addr),
    .annul(annul), .ex_valid(ex_valid), .ex_werf(ex_werf), .ex_is_ld(ex_is_ld),
    .ex_wa(ex_wa), .ex_result(ex_result), .mem_valid(mem_valid), .mem_werf(mem_werf),
    .mem_wa(mem_wa), .mem_result(mem_result), .wb_valid(wb_valid), .wb_werf(wb_werf),
    .wb_wa(wb_wa), .wb_wdata(wb_wdata), .stall(stall), .alu_valid(alu_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_wa(alu_wa), .alu_werf(alu_werf),
    .alu_is_ld(alu_is_ld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit writes(input logic v, input logic w, input logic [4:0] wa,
                                input logic [4:0] x);
    return (v && w && wa == x && x != 5'd31);
  endfunction

  // Value an instruction should see for register x, youngest producer first.
  function automatic logic [31:0] value_of(input logic [4:0] x);
    if (x == 5'd31) return 32'd0;
    if (writes(ex_valid, ex_werf, ex_wa, x)) return ex_result;
    if (writes(mem_valid, mem_werf, mem_wa, x)) return mem_result;
`ifdef OPSTAGE_WB_BYPASS_EN
    if (writes(wb_valid, wb_werf, wb_wa, x)) return wb_wdata;
`endif
    return regs[x];
  endfunction

  task automatic clear_inputs();
    {rf_valid, rf_ra2sel, rf_wasel, rf_werf, rf_is_ld, annul} = 6'd0;
    {rf_ra, rf_rb, rf_rc} = 15'd0;
    {ex_valid, ex_werf, ex_is_ld, mem_valid, mem_werf, wb_valid, wb_werf} = 7'd0;
    {ex_wa, mem_wa, wb_wa} = 15'd0;
    ex_result = 32'd0; mem_result = 32'd0; wb_wdata = 32'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cyc();
    logic [4:0]  b;
    logic        lu, wbs, es;
    logic [31:0] va, vb;
    #2;
    b   = rf_ra2sel ? rf_rc : rf_rb;
    lu  = rf_valid && ex_is_ld &&
          (writes(ex_valid, ex_werf, ex_wa, rf_ra) || writes(ex_valid, ex_werf, ex_wa, b));
`ifdef OPSTAGE_WB_BYPASS_EN
    wbs = 1'b0;
`else
    wbs = rf_valid &&
          (writes(wb_valid, wb_werf, wb_wa, rf_ra) || writes(wb_valid, wb_werf, wb_wa, b));
`endif
    es  = !annul && (lu || wbs);
    va  = value_of(rf_ra);
    vb  = value_of(b);
    stall_seen = stall;
    check("rb_addr", {27'd0, rb_addr}, {27'd0, b});
    check("stall", {31'd0, stall}, {31'd0, es});
    if (reset) begin
      m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_wa = 5'd0; m_werf = 1'b0; m_ld = 1'b0;
    end else if (annul || es || !rf_valid) begin
      m_valid = 1'b0; m_werf = 1'b0; m_ld = 1'b0;
    end else begin
      m_valid = 1'b1; m_a = va; m_b = vb;
      m_wa = rf_wasel ? 5'd30 : rf_rc;
      m_werf = rf_werf; m_ld = rf_is_ld;
    end
    @(posedge clock);
    #1;
    check("alu_valid", {31'd0, alu_valid}, {31'd0, m_valid});
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_wa", {27'd0, alu_wa}, {27'd0, m_wa});
    check("alu_werf", {31'd0, alu_werf}, {31'd0, m_werf});
    check("alu_is_ld", {31'd0, alu_is_ld}, {31'd0, m_ld});
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd4;
      1: return 5'd5;
      2: return 5'd30;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [31:0] mr;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    clear_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    cyc();
    reset = 1'b0;

    // Plain regfile read.
    regs[5] = 32'd3; rf_valid = 1'b1; rf_ra = 5'd5;
    cyc();
    check("rf_read_a", alu_a, 32'd3);
    check("rf_read_valid", {31'd0, alu_valid}, 32'd1);

    // ALU outranks MEM.
    ex_valid = 1'b1; ex_werf = 1'b1; ex_wa = 5'd5; ex_result = 32'd7;
    mem_valid = 1'b1; mem_werf = 1'b1; mem_wa = 5'd5; mem_result = 32'd9;
    cyc();
    check("prio_a", alu_a, 32'd7);

    // Store addressing rc with WB producer.
    clear_inputs();
    regs[5] = 32'd11;
    rf_valid = 1'b1; rf_ra2sel = 1'b1; rf_rc = 5'd5; rf_rb = 5'd2;
    wb_valid = 1'b1; wb_werf = 1'b1; wb_wa = 5'd5; wb_wdata = 32'd2;
    cyc();
`ifdef OPSTAGE_WB_BYPASS_EN
    check("wb_byp_b", alu_b, 32'd2);
`else
    check("wb_stall", {31'd0, stall_seen}, 32'd1);
    regs[5] = 32'd2; wb_valid = 1'b0;
    cyc();
    check("wb_after_b", alu_b, 32'd2);
`endif

    // Load-use on r4, then bypass from MEM.
    clear_inputs();
    rf_valid = 1'b1; rf_ra = 5'd4;
    ex_valid = 1'b1; ex_werf = 1'b1; ex_is_ld = 1'b1; ex_wa = 5'd4;
    cyc();
    check("lu_stall", {31'd0, stall_seen}, 32'd1);
    check("lu_bubble", {31'd0, alu_valid}, 32'd0);
    ex_valid = 1'b0; ex_is_ld = 1'b0;
    mr = $urandom;
    mem_valid = 1'b1; mem_werf = 1'b1; mem_wa = 5'd4; mem_result = mr;
    cyc();
    check("lu_mem_a", alu_a, mr);

    // r31 is never forwarded.
    clear_inputs();
    regs[31] = 32'hDEAD_BEEF;
    rf_valid = 1'b1; rf_ra = 5'd31;
    ex_valid = 1'b1; ex_werf = 1'b1; ex_is_ld = 1'b1; ex_wa = 5'd31; ex_result = 32'hFFFF_FFFF;
    cyc();
    check("zero_a", alu_a, 32'd0);
    check("zero_stall", {31'd0, stall_seen}, 32'd0);

    // Annul beats load-use.
    ex_wa = 5'd4; rf_ra = 5'd4; annul = 1'b1;
    cyc();
    check("annul_stall", {31'd0, stall_seen}, 32'd0);
    check("annul_valid", {31'd0, alu_valid}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      annul = ($urandom_range(0, 7) == 0);
      rf_valid = ($urandom_range(0, 5) != 0);
      rf_ra = pick_reg(); rf_rb = pick_reg(); rf_rc = pick_reg();
      rf_ra2sel = 1'($urandom); rf_wasel = 1'($urandom);
      rf_werf = 1'($urandom); rf_is_ld = 1'($urandom);
      ex_valid = 1'($urandom); ex_werf = 1'($urandom); ex_is_ld = 1'($urandom);
      mem_valid = 1'($urandom); mem_werf = 1'($urandom);
      wb_valid = 1'($urandom); wb_werf = 1'($urandom);
      ex_wa = pick_reg(); mem_wa = pick_reg(); wb_wa = pick_reg();
      ex_result = $urandom; mem_result = $urandom; wb_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) regs[pick_reg()] = $urandom;
      cyc();
    end

    // Final reset clears everything.
    reset = 1'b1;
    cyc();
    check("final_reset_a", alu_a, 32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
